// File: rtl/dmux_pkg.sv
// Shared constants and helpers for the streaming demultiplexer and its channel FIFOs.
package dmux_pkg;

  localparam int ERR_W     = 8;
  localparam int DEF_N     = 3;
  localparam int DEF_NCH   = 4;
  localparam int DEF_DEPTH = 4;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dmux_chan_fifo.sv
// Per-channel FIFO with a registered head-of-queue output; pointers carry one extra
// wrap bit so full and empty are told apart without a separate counter.
module dmux_chan_fifo
  import dmux_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [N-1:0] wdata,
  output logic         full,
  input  logic         pop,
  output logic [N-1:0] rdata,
  output logic         empty
);

  localparam int AW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);

  logic [N-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic [AW:0]  rptr_nxt;
  logic         do_push;
  logic         do_pop;

  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty    = (wptr == rptr);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign rptr_nxt = rptr + 1'b1;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr[AW-1:0]] <= wdata;
    end
  end

  // The head register is reloaded on a pop; if the entry behind the head is being
  // written in the same cycle, it comes straight from wdata rather than the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      rdata <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + 1'b1;
      end
      if (do_pop) begin
        rptr <= rptr_nxt;
        if (do_push && (wptr == rptr_nxt)) begin
          rdata <= wdata;
        end else begin
          rdata <= mem[rptr_nxt[AW-1:0]];
        end
      end else if (do_push && empty) begin
        rdata <= wdata;
      end
    end
  end

endmodule

// File: rtl/dmux_stream.sv
// Streaming demultiplexer: routes each input beat to one of NCH buffered channels;
// beats with an out-of-range select are swallowed and counted.
module dmux_stream
  import dmux_pkg::*;
#(
  parameter  int N     = DEF_N,
  parameter  int NCH   = DEF_NCH,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int SEL_W = (clog2(NCH) < 1) ? 1 : clog2(NCH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       in_data,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [NCH*N-1:0]   out_data,
  output logic [NCH-1:0]     out_valid,
  input  logic [NCH-1:0]     out_ready,
  output logic [ERR_W-1:0]   err_cnt
);

  localparam logic [SEL_W:0] NCH_L = NCH[SEL_W:0];

  logic [NCH-1:0]          full;
  logic [NCH-1:0]          empty;
  logic [(1<<SEL_W)-1:0]   full_ext;
  logic                    in_range;
  logic                    accept;

  // Pad the full flags to every encodable select so the ready mux never indexes out of range.
  always_comb begin
    full_ext = '0;
    for (int c = 0; c < NCH; c++) begin
      full_ext[c] = full[c];
    end
  end

  assign in_range = ({1'b0, in_sel} < NCH_L);
  assign in_ready = in_range ? !full_ext[in_sel] : 1'b1;
  assign accept   = in_valid && in_ready;

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    logic push_c;
    logic pop_c;

    assign push_c       = accept && in_range && (in_sel == SEL_W'(c));
    assign pop_c        = out_valid[c] && out_ready[c];
    assign out_valid[c] = !empty[c];

    dmux_chan_fifo #(
      .N     (N),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_c),
      .wdata (in_data),
      .full  (full[c]),
      .pop   (pop_c),
      .rdata (out_data[c*N +: N]),
      .empty (empty[c])
    );
  end

  // Dropped-beat counter sticks at its maximum instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (accept && !in_range && (err_cnt != {ERR_W{1'b1}})) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule
